// File: rtl/qspi_tx_shift_reg.sv
// QSPI transmit shift register: serialises 1-4 bytes MSB first over 1, 2 or 4 lanes,
// advancing one beat per shift_en pulse from the SCLK generator.
module qspi_tx_shift_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [1:0]  num_bytes,
  input  logic        use_1_io_lines_in,
  input  logic        use_2_io_lines_in,
  input  logic        use_4_io_lines_in,
  input  logic        shift_en,
  input  logic        abort,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        qspi_io0_out,
  output logic        qspi_io1_out,
  output logic        qspi_io2_out,
  output logic        qspi_io3_out,
  output logic        qspi_io0_oe,
  output logic        qspi_io1_oe,
  output logic        qspi_io2_oe,
  output logic        qspi_io3_oe
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  typedef enum logic [1:0] {LANE1 = 2'd0, LANE2 = 2'd1, LANE4 = 2'd2} lane_e;

  state_e      state_q, state_d;
  lane_e       lane_q, lane_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic        modeValid;
  lane_e       loadLane;
  logic [5:0]  payloadBits;

  assign modeValid   = use_1_io_lines_in | use_2_io_lines_in | use_4_io_lines_in;
  assign payloadBits = {({1'b0, num_bytes} + 3'd1), 3'b000};

  always_comb begin
    if (use_1_io_lines_in)      loadLane = LANE1;
    else if (use_2_io_lines_in) loadLane = LANE2;
    else                        loadLane = LANE4;
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load && modeValid) begin
          state_d = SHIFT;
          lane_d  = loadLane;
          // Left-justify so the first transmitted bit sits at bit 31.
          shift_d = data_in << {~num_bytes, 3'b000};
          case (loadLane)
            LANE1:   cnt_d = payloadBits;
            LANE2:   cnt_d = payloadBits >> 1;
            default: cnt_d = payloadBits >> 2;
          endcase
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          shift_d = '0;
          cnt_d   = '0;
        end else if (shift_en) begin
          case (lane_q)
            LANE1:   shift_d = {shift_q[30:0], 1'b0};
            LANE2:   shift_d = {shift_q[29:0], 2'b00};
            default: shift_d = {shift_q[27:0], 4'b0000};
          endcase
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= LANE1;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Pins are driven only while shifting; unused lanes stay low and undriven.
  always_comb begin
    qspi_io0_out = 1'b0;
    qspi_io1_out = 1'b0;
    qspi_io2_out = 1'b0;
    qspi_io3_out = 1'b0;
    qspi_io0_oe  = 1'b0;
    qspi_io1_oe  = 1'b0;
    qspi_io2_oe  = 1'b0;
    qspi_io3_oe  = 1'b0;
    if (state_q == SHIFT) begin
      case (lane_q)
        LANE1: begin
          qspi_io0_out = shift_q[31];
          qspi_io0_oe  = 1'b1;
        end
        LANE2: begin
          qspi_io1_out = shift_q[31];
          qspi_io0_out = shift_q[30];
          qspi_io0_oe  = 1'b1;
          qspi_io1_oe  = 1'b1;
        end
        default: begin
          qspi_io3_out = shift_q[31];
          qspi_io2_out = shift_q[30];
          qspi_io1_out = shift_q[29];
          qspi_io0_out = shift_q[28];
          qspi_io0_oe  = 1'b1;
          qspi_io1_oe  = 1'b1;
          qspi_io2_oe  = 1'b1;
          qspi_io3_oe  = 1'b1;
        end
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == SHIFT);
  assign done  = done_q;

endmodule

// File: doc/qspi_tx_shift_reg.md
QSPI_TX_SHIFT_REG -- requirements
Module: qspi_tx_shift_reg

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  system clock (HCLK)
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  start a transfer with data_in
- data_in  in  32  word to transmit; the low 8*(num_bytes+1) bits are sent
- num_bytes  in  2  bytes to send minus one (0..3 = 1..4 bytes)
- use_1_io_lines_in / use_2_io_lines_in / use_4_io_lines_in  in  1 each  lane mode select
- shift_en  in  1  one-cycle shift pulse from the SCLK generator
- abort  in  1  synchronous cancel
- ready  out  1  idle, load accepted
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- qspi_io0_out..qspi_io3_out  out  1 each  pin drive values
- qspi_io0_oe..qspi_io3_oe  out  1 each  pin output enables
REQ-002 SHALL have no parameters; data width is fixed at 32 bits.

Function
REQ-003 SHALL implement FSM states IDLE and SHIFT; ready=(state==IDLE); busy=(state==SHIFT).
REQ-004 Load acceptance: load=1 in IDLE with at least one mode bit set SHALL capture data_in, num_bytes and mode, then enter SHIFT on the next clk edge.
REQ-005 Mode priority at load SHALL be 1-line > 2-line > 4-line, giving lane width W = 1, 2 or 4.
REQ-006 load with no mode bit set SHALL be ignored; state stays IDLE and no outputs change.
REQ-007 Capture SHALL left-justify the payload: shift_reg = data_in << (32 - 8*(num_bytes+1)), so transmission is MSB first.
REQ-008 Capture SHALL set beat counter = 8*(num_bytes+1)/W (range 2..32; counter is 6 bits).
REQ-009 Pin mapping in SHIFT, s = shift_reg:
- W=1: io0=s[31]
- W=2: io1=s[31], io0=s[30]
- W=4: io3=s[31], io2=s[30], io1=s[29], io0=s[28]
REQ-010 Unused lanes SHALL drive 0 with oe=0.
REQ-011 OE SHALL be active only in SHIFT:
- W=1: oe0
- W=2: oe0, oe1
- W=4: oe0..oe3
REQ-012 The first beat SHALL be valid on the pins in the first cycle of SHIFT, one cycle after the load edge.
REQ-013 shift_en in SHIFT SHALL shift shift_reg left by W (zero fill) and decrement the counter.
REQ-014 shift_en in SHIFT with counter==1 SHALL return to IDLE, pulse done for exactly 1 cycle, and drop all oe in the same edge.
REQ-015 shift_en in IDLE SHALL be ignored.
REQ-016 Mode inputs, num_bytes and data_in SHALL be ignored during SHIFT (values latched at load).
REQ-017 load during SHIFT SHALL be ignored, including in the cycle of the final shift_en; no queuing.
REQ-018 abort in SHIFT SHALL return to IDLE on the next edge with oe=0, io_out=0 and no done pulse.
REQ-019 abort SHALL take priority over a simultaneous shift_en.
REQ-020 abort in IDLE SHALL be ignored; simultaneous load and abort in IDLE SHALL accept the load.
REQ-021 In IDLE all qspi_io*_out SHALL be 0 and all oe SHALL be 0.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: state=IDLE, shift_reg=0, counter=0, ready=1, busy=0, done=0, all io_out=0, all oe=0.
REQ-023 Reset asserted mid-transfer SHALL abort immediately with no done pulse; the first load after rst_n release SHALL be accepted normally.

Verification
REQ-024 1-line, num_bytes=0, data_in=0x000000A5 -> io0 = 1,0,1,0,0,1,0,1 over 8 shift_en; only oe0 high; done 1 cycle after the 8th shift_en edge.
REQ-025 4-line, num_bytes=3, data_in=0x12345678 -> {io3..io0} = 1,2,3,4,5,6,7,8 over 8 shift_en; oe=4'hF; then done pulse.
REQ-026 2-line, num_bytes=1, data_in=0xFFFFC3A5 -> {io1,io0} = 3,0,0,3,2,2,1,1 over 8 shift_en; oe0/oe1 only; upper 16 bits never appear.
REQ-027 1-line, num_bytes=3 transfer: after 5 shift_en, pulse load with new data and flip the mode to 4-line -> transfer continues unchanged for 32 total shift_en; exactly 1 done pulse.
REQ-028 Abort after 3 beats -> IDLE next cycle, oe=0, no done; separately, rst_n low mid-transfer -> immediate idle outputs; a subsequent load sends correctly.
REQ-029 shift_en pulses in IDLE, and load with all mode bits 0 -> no state change, oe stay 0, ready stays 1.
